// File: rtl/matrix_result_streamer.sv
// Snapshots matrix_mult's C once its pipeline latency has elapsed, then streams it row-major over valid/ready.
// Optional feature MATRIX_STREAM_CHECKSUM_EN adds a checksum output summing every transferred element.
module matrix_result_streamer #(
   parameter int N           = 4,
   parameter int WIDTH       = 16,
   parameter int PIPE_STAGES = 2,
   localparam int DW         = 2*WIDTH,
   localparam int IW         = (N > 1) ? $clog2(N) : 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [N-1:0][N-1:0][DW-1:0] C,
   output logic                        busy,
   output logic [DW-1:0]               out_data,
   output logic [IW-1:0]               out_row,
   output logic [IW-1:0]               out_col,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        out_last,
   output logic                        done
`ifdef MATRIX_STREAM_CHECKSUM_EN
   ,output logic [DW+2*IW-1:0]         checksum
`endif
);

   localparam int            CNTW     = (PIPE_STAGES > 1) ? $clog2(PIPE_STAGES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(N-1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STREAM} state_t;

   state_t                      state, state_n;
   logic [CNTW-1:0]             cnt;
   logic [IW-1:0]               r, c;
   logic [N-1:0][N-1:0][DW-1:0] mbuf;
   logic                        capture, accept, xfer, at_end;

   assign accept    = (state == S_IDLE) && start;
   assign out_valid = (state == S_STREAM);
   assign xfer      = out_valid && out_ready;
   assign at_end    = (r == LAST_IDX) && (c == LAST_IDX);
   assign out_last  = out_valid && at_end;
   assign busy      = (state != S_IDLE);
   assign out_row   = r;
   assign out_col   = c;
   // Buffer is not reset, so gate the data to keep it zero outside a stream.
   assign out_data  = out_valid ? mbuf[r][c] : '0;

   always_comb begin
      state_n = state;
      capture = 1'b0;
      case (state)
         S_IDLE:
            if (start) begin
               if (PIPE_STAGES == 0) begin
                  capture = 1'b1;
                  state_n = S_STREAM;
               end else begin
                  state_n = S_WAIT;
               end
            end
         S_WAIT:
            if (cnt == '0) begin
               capture = 1'b1;
               state_n = S_STREAM;
            end
         S_STREAM:
            if (xfer && at_end) state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
         r     <= '0;
         c     <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         done  <= xfer && at_end;
         if (accept)
            cnt <= CNTW'((PIPE_STAGES > 0) ? PIPE_STAGES - 1 : 0);
         else if (state == S_WAIT && cnt != '0)
            cnt <= cnt - 1'b1;
         if (xfer) begin
            if (at_end) begin
               r <= '0;
               c <= '0;
            end else if (c == LAST_IDX) begin
               c <= '0;
               r <= r + 1'b1;
            end else begin
               c <= c + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (capture) mbuf <= C;
   end

`ifdef MATRIX_STREAM_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (rst || accept)
         checksum <= '0;
      else if (xfer)
         checksum <= checksum + (DW+2*IW)'(out_data);
   end
`endif

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Bench for matrix_result_streamer: two instances (PIPE_STAGES=2 and 0) share directed stimulus and are
// checked each cycle against a transfer-count model, plus literal stream/timing expectations.
module tb_matrix_result_streamer;
   localparam int N = 4, WIDTH = 16, DW = 32, IW = 2, NN = 16, CKW = DW + 2*IW;

   logic clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b1;
   logic [N-1:0][N-1:0][DW-1:0] cm;
   logic          busy[2], out_valid[2], out_last[2], done[2];
   logic [DW-1:0] out_data[2];
   logic [IW-1:0] out_row[2], out_col[2];
`ifdef MATRIX_STREAM_CHECKSUM_EN
   logic [CKW-1:0] checksum[2];
`endif

   always #5 clk = ~clk;

   matrix_result_streamer #(.N(N), .WIDTH(WIDTH), .PIPE_STAGES(2)) u_p2 (
      .clk(clk), .rst(rst), .start(start), .C(cm), .busy(busy[0]), .out_data(out_data[0]),
      .out_row(out_row[0]), .out_col(out_col[0]), .out_valid(out_valid[0]), .out_ready(out_ready),
      .out_last(out_last[0]), .done(done[0])
`ifdef MATRIX_STREAM_CHECKSUM_EN
      , .checksum(checksum[0])
`endif
   );

   matrix_result_streamer #(.N(N), .WIDTH(WIDTH), .PIPE_STAGES(0)) u_p0 (
      .clk(clk), .rst(rst), .start(start), .C(cm), .busy(busy[1]), .out_data(out_data[1]),
      .out_row(out_row[1]), .out_col(out_col[1]), .out_valid(out_valid[1]), .out_ready(out_ready),
      .out_last(out_last[1]), .done(done[1])
`ifdef MATRIX_STREAM_CHECKSUM_EN
      , .checksum(checksum[1])
`endif
   );

   int n_chk = 0, n_fail = 0;

   function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endfunction

   // Model: an accepted start at cycle s presents element k (k transfers done) from cycle s+P+1 on.
   int  PS[2] = '{2, 0};
   int  cyc = 0;
   bit  chk_en = 1'b0;
   bit  m_act[2];
   int  m_st[2], m_k[2];
   int  m_done[2] = '{-1, -1};
   longint m_ck[2];
   logic [N-1:0][N-1:0][DW-1:0] m_snap[2];

   function automatic longint msum(input logic [N-1:0][N-1:0][DW-1:0] m);
      longint s = 0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) s += longint'(m[i][j]);
      return s;
   endfunction

   initial forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            m_act[d] = 1'b0; m_k[d] = 0; m_done[d] = -1; m_ck[d] = 0;
         end else if (m_act[d]) begin
            if (PS[d] > 0 && cyc == m_st[d] + PS[d]) m_snap[d] = cm;
            if (cyc >= m_st[d] + PS[d] + 1 && out_ready) begin
               m_k[d]++;
               if (m_k[d] == NN) begin
                  m_act[d] = 1'b0; m_k[d] = 0; m_done[d] = cyc + 1; m_ck[d] = msum(m_snap[d]);
               end
            end
         end else if (start) begin
            m_act[d] = 1'b1; m_st[d] = cyc; m_k[d] = 0;
            if (PS[d] == 0) m_snap[d] = cm;
         end
      end
      if (rst) chk_en = 1'b1;
      cyc++;
   end

   // Logs of what each instance actually transferred.
   logic [DW-1:0]   lg[2][$];
   int              fv[2], last_pos[2], done_cnt[2], done_at[2];
   logic [2*IW-1:0] last_rc[2];

   initial begin
      bit ev;
      int er, ec;
      logic [DW-1:0] ed;
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (chk_en) begin
               ev = m_act[d] && (cyc >= m_st[d] + PS[d] + 1);
               er = ev ? m_k[d] / N : 0;
               ec = ev ? m_k[d] % N : 0;
               ed = ev ? m_snap[d][er][ec] : '0;
               check($sformatf("dut%0d cyc%0d busy/valid/last/done/row/col/data", d, cyc),
                     64'({busy[d], out_valid[d], out_last[d], done[d], out_row[d], out_col[d], out_data[d]}),
                     64'({m_act[d], ev, ev && (m_k[d] == NN-1), cyc == m_done[d], IW'(er), IW'(ec), ed}));
`ifdef MATRIX_STREAM_CHECKSUM_EN
               if (!m_act[d])
                  check($sformatf("dut%0d cyc%0d checksum", d, cyc), 64'(checksum[d]), 64'(m_ck[d]));
`endif
            end
            if (out_valid[d] === 1'b1) begin
               if (fv[d] < 0) fv[d] = cyc;
               if (out_ready) begin
                  lg[d].push_back(out_data[d]);
                  if (out_last[d] === 1'b1) begin
                     last_pos[d] = lg[d].size() - 1;
                     last_rc[d]  = {out_row[d], out_col[d]};
                  end
               end
            end
            if (done[d] === 1'b1) begin
               done_cnt[d]++;
               done_at[d] = cyc;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      for (int d = 0; d < 2; d++) begin
         lg[d].delete(); fv[d] = -1; last_pos[d] = -1; done_cnt[d] = 0; done_at[d] = -1; last_rc[d] = '0;
      end
   endtask

   task automatic pulse_start(output int s);
      s = cyc;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int d, input int lim, input string nm);
      int n = 0;
      while (done[d] !== 1'b1 && n < lim) begin
         tick();
         n++;
      end
      check({nm, " done within budget"}, 64'(done[d]), 64'(1));
   endtask

   task automatic check_stream(input int d, input string nm, input int e[NN]);
      check({nm, " count"}, 64'(lg[d].size()), 64'(NN));
      for (int i = 0; i < NN && i < lg[d].size(); i++)
         check($sformatf("%s elem%0d", nm, i), 64'(lg[d][i]), 64'(e[i]));
      check({nm, " last position"}, 64'(last_pos[d]), 64'(NN-1));
      check({nm, " last row/col"}, 64'(last_rc[d]), 64'(4'hF));
   endtask

   task automatic set_all(input int v);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) cm[i][j] = DW'(v);
   endtask

   task automatic set_ipj();
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) cm[i][j] = DW'(i + j);
   endtask

   initial begin
      int ipj[NN] = '{0,1,2,3, 1,2,3,4, 2,3,4,5, 3,4,5,6};
      int all5[NN], all9[NN];
      int s, n, d0;
      for (int i = 0; i < NN; i++) begin
         all5[i] = 5;
         all9[i] = 9;
      end
      clear_logs();
      set_ipj();
      tick(); tick();
      rst = 1'b0;
      check("reset state p2", 64'({busy[0], out_valid[0], out_last[0], done[0], out_row[0], out_col[0], out_data[0]}), 64'(0));
      check("reset state p0", 64'({busy[1], out_valid[1], out_last[1], done[1], out_row[1], out_col[1], out_data[1]}), 64'(0));
      tick();

      // Row-major stream
      clear_logs();
      pulse_start(s);
      wait_done(0, 40, "s1");
      tick();
      check("s1 p2 first valid cycle", 64'(fv[0] - s), 64'(3));
      check("s1 p2 done cycle", 64'(done_at[0] - s), 64'(19));
      check("s1 p0 first valid cycle", 64'(fv[1] - s), 64'(1));
      check_stream(0, "s1 p2", ipj);
      check_stream(1, "s1 p0", ipj);
`ifdef MATRIX_STREAM_CHECKSUM_EN
      check("s1 p2 checksum", 64'(checksum[0]), 64'(48));
`endif
      tick();

      // Backpressure while (1,1) is presented
      clear_logs();
      pulse_start(s);
      n = 0;
      while (!(out_valid[0] === 1'b1 && out_row[0] == 2'd1 && out_col[0] == 2'd1) && n < 20) begin
         tick();
         n++;
      end
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("s2 hold cycle%0d", i),
               64'({out_data[0], out_row[0], out_col[0], out_valid[0], out_last[0]}),
               64'({32'd2, 2'd1, 2'd1, 1'b1, 1'b0}));
         tick();
      end
      out_ready = 1'b1;
      wait_done(0, 40, "s2");
      tick();
      check_stream(0, "s2 p2", ipj);
      check_stream(1, "s2 p0", ipj);
      tick();

      // Start while busy is ignored
      clear_logs();
      pulse_start(s);
      repeat (4) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (30) tick();
      check("s3 p2 transfers", 64'(lg[0].size()), 64'(NN));
      check("s3 p2 done pulses", 64'(done_cnt[0]), 64'(1));
      check("s3 p0 transfers", 64'(lg[1].size()), 64'(NN));
      check("s3 p0 done pulses", 64'(done_cnt[1]), 64'(1));

      // Reset after 7 transfers
      clear_logs();
      pulse_start(s);
      n = 0;
      while (lg[0].size() < 7 && n < 30) begin
         tick();
         n++;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("s4 after reset p2", 64'({busy[0], out_valid[0], done[0], out_row[0], out_col[0]}), 64'(0));
      repeat (5) tick();
      check("s4 no done p2", 64'(done_cnt[0]), 64'(0));
      check("s4 no done p0", 64'(done_cnt[1]), 64'(0));
      clear_logs();
      pulse_start(s);
      wait_done(0, 40, "s4");
      tick();
      check_stream(0, "s4 restart p2", ipj);
      tick();

      // Capture isolation: C changes two cycles after start
      set_all(5);
      clear_logs();
      pulse_start(s);
      tick();
      set_all(9);
      wait_done(0, 40, "s5");
      tick();
      check("s5 p0 first valid cycle", 64'(fv[1] - s), 64'(1));
      check_stream(1, "s5 p0", all5);
      check_stream(0, "s5 p2", all9);
`ifdef MATRIX_STREAM_CHECKSUM_EN
      check("s5 p0 checksum", 64'(checksum[1]), 64'(80));
      check("s5 p2 checksum", 64'(checksum[0]), 64'(144));
`endif
      tick();

      // Back-to-back: start in the done cycle
      set_ipj();
      clear_logs();
      pulse_start(s);
      wait_done(0, 40, "s6 first");
      d0 = cyc;
      start = 1'b1;
      clear_logs();
      tick();
      start = 1'b0;
      wait_done(0, 40, "s6 second");
      tick();
      check("s6 p2 second first valid", 64'(fv[0] - d0), 64'(3));
      check("s6 p0 second first valid", 64'(fv[1] - d0), 64'(1));
      check_stream(0, "s6 p2", ipj);
      repeat (3) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got no completion, expected summary");
      $fatal(1, "watchdog");
   end

endmodule
